mem_port_arbiter: RTL and testbench

- Shares one single-port, word-wide instruction/data memory between two requesters: the instruction-fetch port and the load/store data port of the multicycle RV32I core.
- Arbitrates between them and sequences one memory transaction at a time with a req/gnt/rvalid handshake.
- Routes the registered response back to the owner.
- Sits between the fetch/LSU stages and the memory model; replaces the separate IMEM/DMEM of the single-cycle core.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_prio.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_LIM_DEF = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first priority decision with a saturating fetch-starvation counter.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   if_req_i,
  input  logic   ls_req_i,
  input  logic   arb_i,
  output owner_e win_o,
  output logic   vld_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starved;

  assign starved = (cnt_q == CNT_W'(STARVE_LIM)) && if_req_i;
  assign vld_o   = arb_i && (if_req_i || ls_req_i);

  always_comb begin
    win_o = OWN_IF;
    if (ls_req_i && !starved) win_o = OWN_LS;
  end

  // Only data wins taken while fetch is waiting count towards starvation.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_o) begin
      if (win_o == OWN_LS && if_req_i) begin
        if (cnt_q != CNT_W'(STARVE_LIM)) cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters.
// Optional sticky protocol checker enabled by defining MEM_ARB_ERR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_W-1:0]     o_if_rdata,
  input  logic                  i_ls_req,
  input  logic                  i_ls_we,
  input  logic [ADDR_W-1:0]     i_ls_addr,
  input  logic [DATA_W-1:0]     i_ls_wdata,
  input  logic [DATA_W/8-1:0]   i_ls_be,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [DATA_W-1:0]     o_ls_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_be,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, win;
  logic                arb, win_vld;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                if_rvalid_q, ls_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;

  // Arbitration points: idle, and the response cycle so back-to-back has no bubble.
  assign arb = (state_q == IDLE) || (state_q == WAIT && i_mem_rvalid);

  mem_arb_prio #(.STARVE_LIM(STARVE_LIM)) u_prio (
    .clk_i    (i_clk),
    .rst_i    (i_reset),
    .if_req_i (i_if_req),
    .ls_req_i (i_ls_req),
    .arb_i    (arb),
    .win_o    (win),
    .vld_o    (win_vld)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld) state_d = REQ;
      REQ:     if (i_mem_gnt) state_d = WAIT;
      WAIT:    if (i_mem_rvalid) state_d = win_vld ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_if_gnt = 1'b0;
    o_ls_gnt = 1'b0;
    if (state_q == REQ) begin
      o_if_gnt = i_mem_gnt && (owner_q == OWN_IF);
      o_ls_gnt = i_mem_gnt && (owner_q == OWN_LS);
    end
  end

  assign o_busy = (state_q != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if (state_q == WAIT && i_mem_rvalid) begin
        if (owner_q == OWN_IF) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= i_mem_rdata;
        end else begin
          ls_rvalid_q <= 1'b1;
          ls_rdata_q  <= i_mem_rdata;
        end
      end
      if (state_q == REQ && i_mem_gnt) mem_req_q <= 1'b0;
      if (win_vld) begin
        owner_q   <= win;
        mem_req_q <= 1'b1;
        if (win == OWN_LS) begin
          mem_we_q    <= i_ls_we;
          mem_addr_q  <= i_ls_addr;
          mem_wdata_q <= i_ls_wdata;
          mem_be_q    <= i_ls_be;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= i_if_addr;
          mem_wdata_q <= '0;
          mem_be_q    <= '1;
        end
      end
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_be    = mem_be_q;
  assign o_if_rvalid = if_rvalid_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;

`ifdef MEM_ARB_ERR_EN
  logic err_q, if_pend_q, ls_pend_q, err_set;

  // A request still waiting for its grant must not be withdrawn.
  always_comb begin
    err_set = (i_mem_rvalid && state_q != WAIT) ||
              (i_mem_gnt && state_q != REQ) ||
              (i_ls_req && i_ls_we && i_ls_be == '0) ||
              (if_pend_q && !i_if_req) ||
              (ls_pend_q && !i_ls_req);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_q     <= 1'b0;
      if_pend_q <= 1'b0;
      ls_pend_q <= 1'b0;
    end else begin
      err_q     <= err_q || err_set;
      if_pend_q <= i_if_req && !o_if_gnt;
      ls_pend_q <= i_ls_req && !o_ls_gnt;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed checks.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
`ifdef MEM_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req, i_ls_we;
  logic [31:0] i_ls_addr, i_ls_wdata;
  logic [3:0]  i_ls_be;
  logic        o_ls_gnt, o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_gnt, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy, o_err;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_3093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit          m_active, m_granted, m_own_ls;
  bit          m_if_rv, m_ls_rv;
  logic [31:0] m_if_rd, m_ls_rd, m_addr, m_wd;
  logic [3:0]  m_be;
  bit          m_we;
  int          m_cnt;
  bit          g_if, g_ls;
  int          gseq[$];

  task automatic mdl_reset();
    m_active = 0; m_granted = 0; m_own_ls = 0; m_if_rv = 0; m_ls_rv = 0;
    m_if_rd = '0; m_ls_rd = '0; m_addr = '0; m_wd = '0; m_be = '0; m_we = 0; m_cnt = 0;
  endtask

  task automatic mdl_step();
    bit nif, nls, pick_point, ls_wins;
    nif = 0; nls = 0;
    pick_point = !m_active || (m_granted && i_mem_rvalid);
    if (m_active && m_granted && i_mem_rvalid) begin
      if (m_own_ls) begin nls = 1; m_ls_rd = i_mem_rdata; end
      else          begin nif = 1; m_if_rd = i_mem_rdata; end
    end
    if (m_active && !m_granted && i_mem_gnt) m_granted = 1;
    if (pick_point) begin
      if (i_if_req || i_ls_req) begin
        ls_wins = i_ls_req && !(m_cnt == LIM && i_if_req);
        if (ls_wins) begin
          m_cnt = i_if_req ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
          m_own_ls = 1; m_we = i_ls_we; m_addr = i_ls_addr; m_wd = i_ls_wdata; m_be = i_ls_be;
        end else begin
          m_cnt = 0;
          m_own_ls = 0; m_we = 0; m_addr = i_if_addr; m_be = 4'hF;
        end
        m_active = 1; m_granted = 0;
      end else begin
        m_active = 0; m_granted = 0;
      end
    end
    m_if_rv = nif; m_ls_rv = nls;
  endtask

  always @(negedge i_clk) begin
    if (i_reset) mdl_reset();
    chk("busy",      32'(o_busy),      32'(m_active));
    chk("mem_req",   32'(o_mem_req),   32'(m_active && !m_granted));
    chk("mem_addr",  o_mem_addr,       m_addr);
    chk("mem_we",    32'(o_mem_we),    32'(m_we));
    chk("mem_be",    32'(o_mem_be),    32'(m_be));
    if (m_we) chk("mem_wdata", o_mem_wdata, m_wd);
    chk("if_gnt",    32'(o_if_gnt),    32'(m_active && !m_granted && i_mem_gnt && !m_own_ls));
    chk("ls_gnt",    32'(o_ls_gnt),    32'(m_active && !m_granted && i_mem_gnt && m_own_ls));
    chk("if_rvalid", 32'(o_if_rvalid), 32'(m_if_rv));
    chk("ls_rvalid", 32'(o_ls_rvalid), 32'(m_ls_rv));
    chk("if_rdata",  o_if_rdata,       m_if_rd);
    chk("ls_rdata",  o_ls_rdata,       m_ls_rd);
    g_if = o_if_gnt;
    g_ls = o_ls_gnt;
    if (o_if_gnt) gseq.push_back(0);
    if (o_ls_gnt) gseq.push_back(1);
    if (!i_reset) mdl_step();
  end

  // ---------------- stimulus: requesters and memory responder ----------------
  bit          auto_mem, rv_due, hold_if, hold_ls;
  int          gnt_dly, wait_n;
  logic [31:0] rv_data;

  task automatic step();
    @(posedge i_clk);
    #1;
    if (g_if && !hold_if) i_if_req = 1'b0;
    if (g_ls && !hold_ls) i_ls_req = 1'b0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    if (auto_mem) begin
      if (rv_due) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rv_data;
        rv_due       = 0;
      end
      if (o_mem_req) begin
        if (wait_n >= gnt_dly) begin
          i_mem_gnt = 1'b1;
          rv_due    = 1;
          rv_data   = o_mem_we ? 32'h0 : rd_val(o_mem_addr);
          wait_n    = 0;
        end else begin
          wait_n++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[6];
    exp_seq = '{1, 1, 1, 1, 0, 1};
    i_reset = 1'b1; i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_be = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    auto_mem = 1; rv_due = 0; hold_if = 0; hold_ls = 0; gnt_dly = 0; wait_n = 0; rv_data = '0;

    // Reset state
    step(); step(); @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    step(); i_reset = 1'b0;
    step();

    // Single fetch, best-case latency
    i_if_req = 1'b1; i_if_addr = 32'h0000_0010;
    @(negedge i_clk); chk("sf_c0_req", 32'(o_mem_req), 32'd0);
    step(); @(negedge i_clk);
    chk("sf_c1_req", 32'(o_mem_req), 32'd1);
    chk("sf_c1_addr", o_mem_addr, 32'h10);
    chk("sf_c1_gnt", 32'(o_if_gnt), 32'd1);
    step(); @(negedge i_clk); chk("sf_c2_rv", 32'(o_if_rvalid), 32'd0);
    step(); @(negedge i_clk);
    chk("sf_c3_rv", 32'(o_if_rvalid), 32'd1);
    chk("sf_c3_rd", o_if_rdata, 32'h0051_3093);
    chk("sf_c3_lsrv", 32'(o_ls_rvalid), 32'd0);
    step(); @(negedge i_clk);
    chk("sf_c4_rv", 32'(o_if_rvalid), 32'd0);
    chk("sf_c4_busy", 32'(o_busy), 32'd0);

    // Simultaneous fetch and load: data first, fetch back-to-back
    step();
    i_if_req = 1'b1; i_if_addr = 32'h20;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h100; i_ls_be = 4'hF;
    step(); @(negedge i_clk);
    chk("sim_c1_addr", o_mem_addr, 32'h100);
    chk("sim_c1_lsgnt", 32'(o_ls_gnt), 32'd1);
    step(); @(negedge i_clk); chk("sim_c2_busy", 32'(o_busy), 32'd1);
    step(); @(negedge i_clk);
    chk("sim_c3_req", 32'(o_mem_req), 32'd1);
    chk("sim_c3_addr", o_mem_addr, 32'h20);
    chk("sim_c3_lsrv", 32'(o_ls_rvalid), 32'd1);
    chk("sim_c3_lsrd", o_ls_rdata, 32'hA5A5_0100);
    step(); @(negedge i_clk); chk("sim_c4_busy", 32'(o_busy), 32'd1);
    step(); @(negedge i_clk);
    chk("sim_c5_ifrv", 32'(o_if_rvalid), 32'd1);
    chk("sim_c5_ifrd", o_if_rdata, 32'hA5A5_0020);

    // Store with grant delayed three cycles
    step();
    gnt_dly = 3; wait_n = 0;
    i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h200; i_ls_wdata = 32'hDEAD_BEEF; i_ls_be = 4'b0011;
    for (int c = 1; c <= 4; c++) begin
      step(); @(negedge i_clk);
      chk("st_req", 32'(o_mem_req), 32'd1);
      chk("st_addr", o_mem_addr, 32'h200);
      chk("st_we", 32'(o_mem_we), 32'd1);
      chk("st_wdata", o_mem_wdata, 32'hDEAD_BEEF);
      chk("st_be", 32'(o_mem_be), 32'h3);
      chk("st_gnt", 32'(o_ls_gnt), 32'(c == 4));
    end
    step(); @(negedge i_clk); chk("st_c5_rv", 32'(o_ls_rvalid), 32'd0);
    step(); @(negedge i_clk); chk("st_c6_rv", 32'(o_ls_rvalid), 32'd1);
    step(); @(negedge i_clk); chk("st_c7_rv", 32'(o_ls_rvalid), 32'd0);
    gnt_dly = 0; i_ls_we = 1'b0;

    // Starvation: both held, expect L L L L I L
    step();
    gseq.delete();
    hold_if = 1; hold_ls = 1;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_ls_req = 1'b1; i_ls_addr = 32'h300; i_ls_be = 4'hF;
    for (int k = 0; k < 80 && gseq.size() < 6; k++) step();
    hold_if = 0; hold_ls = 0; i_if_req = 1'b0; i_ls_req = 1'b0;
    chk("starve_ngrants", 32'(gseq.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < gseq.size(); i++)
      chk($sformatf("starve_grant%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
    for (int k = 0; k < 20 && o_busy; k++) step();
    @(negedge i_clk); chk("starve_idle", 32'(o_busy), 32'd0);

    // Reset in WAIT, then a stray response after release
    step();
    auto_mem = 0; rv_due = 0; wait_n = 0;
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h80;
    step(); i_mem_gnt = 1'b1;
    @(negedge i_clk); chk("rm_c1_gnt", 32'(o_ls_gnt), 32'd1);
    step(); @(negedge i_clk); chk("rm_c2_busy", 32'(o_busy), 32'd1);
    step(); i_reset = 1'b1;
    @(negedge i_clk);
    chk("rm_rst_busy", 32'(o_busy), 32'd0);
    chk("rm_rst_req", 32'(o_mem_req), 32'd0);
    step(); i_reset = 1'b0;
    step(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234;
    @(negedge i_clk); chk("rm_stray_busy", 32'(o_busy), 32'd0);
    step(); @(negedge i_clk);
    chk("rm_lsrv", 32'(o_ls_rvalid), 32'd0);
    chk("rm_ifrv", 32'(o_if_rvalid), 32'd0);
    chk("rm_lsrd", o_ls_rdata, 32'd0);
    chk("rm_ifrd", o_if_rdata, 32'd0);
    chk("rm_addr", o_mem_addr, 32'd0);

    // Stray response in IDLE: sticky error only when the checker is built in
    step(); i_reset = 1'b1;
    step(); i_reset = 1'b0;
    step(); @(negedge i_clk); chk("err_init", 32'(o_err), 32'd0);
    step(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555;
    step(); @(negedge i_clk); chk("err_set", 32'(o_err), 32'(ERR_EXP));
    step(); step(); @(negedge i_clk); chk("err_sticky", 32'(o_err), 32'(ERR_EXP));
    step(); i_reset = 1'b1;
    @(negedge i_clk); chk("err_clr", 32'(o_err), 32'd0);
    step(); i_reset = 1'b0;
    step(); @(negedge i_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
